// File: rtl/sync_debouncer.sv
// sync_debouncer: multi-channel input conditioner for asynchronous pins.
//
// Each channel passes through a STAGES-deep flip-flop synchronizer and then
// a debounce filter. The filter accepts a new level only once it has been
// seen for DEBOUNCE_CYCLES consecutive cycles. A pin change that settles
// before a rising edge appears on stable exactly STAGES+DEBOUNCE_CYCLES
// edges later.
//
// Optional feature macro: SYNC_DEBOUNCER_EDGE_EN
//   defined   : rise / fall / any_change are registered one-cycle pulses
//               that line up with the cycle in which stable changes.
//   undefined : the edge registers are left out and the three pulse
//               outputs are tied to 0. stable behaves the same either way,
//               and the port list does not change.
//
// Interface timing: there is no valid/ready handshake. stable is a level
// that is valid on every cycle. rise, fall and any_change are valid on
// every cycle and stay high for exactly one cycle per accepted change.
// reset is asynchronous and active-low. It clears every register at once.

module sync_debouncer #(
  parameter int WIDTH           = 4,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncinput,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // The counter holds values 0..DEBOUNCE_CYCLES-1. The width leaves room
  // for DEBOUNCE_CYCLES, so a DEBOUNCE_CYCLES of 1 still gets a 1-bit
  // counter.
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Synchronizer chain. Index 0 samples the pin and index STAGES-1 is the
  // synchronized level.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             sync_raw;

  // Per-channel debounce counters and the next-state values for them.
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;
  logic [WIDTH-1:0]         stable_d;

  assign sync_raw = sync_q[STAGES-1];

  // Shift the raw pins through the synchronizer, one stage per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], asyncinput};
    end
  end

  // Debounce decision, done for each channel on its own.
  // - Input matches stable: the count restarts, so a bounce back to the
  //   old level always throws away the progress made so far.
  // - Input differs and the count is at its limit: take the new level.
  // - Input differs otherwise: count up. The limit check above means the
  //   counter never goes past CNT_MAX and never wraps.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_raw[i] == stable[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync_raw[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Store the debounced level and the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      cnt_q  <= '0;
    end else begin
      stable <= stable_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SYNC_DEBOUNCER_EDGE_EN
  // The edge pulses are built from the same next-state value as stable,
  // so each pulse is high in the same cycle that stable shows its new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      rise       <= stable_d & ~stable;
      fall       <= stable & ~stable_d;
      any_change <= |(stable_d ^ stable);
    end
  end
`else
  assign rise       = '0;
  assign fall       = '0;
  assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debouncer.sv
// Testbench for sync_debouncer.
// The main instance uses the default parameters. The second instance uses
// STAGES=3 and DEBOUNCE_CYCLES=1. Stimulus tasks push each expected change
// of stable, together with the clock cycle it should appear in, into a
// queue. A monitor for each instance pops an entry and compares it every
// time stable changes. On every other cycle the monitor checks that the
// pulse outputs are 0.

module tb_sync_debouncer;

  localparam int EW       = 32;
  localparam int LAT_MAIN = 2 + 4;  // STAGES + DEBOUNCE_CYCLES
  localparam int LAT_AUX  = 3 + 1;
`ifdef SYNC_DEBOUNCER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] a_main, a_aux;
  logic [3:0] stable_main, rise_main, fall_main;
  logic [3:0] stable_aux, rise_aux, fall_aux;
  logic       any_main, any_aux;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp2_q[$];
  logic [3:0]    s_model, s2_model;
  logic [3:0]    last_main, last_aux;
  logic [EW-1:0] e_main, e_aux;

  sync_debouncer #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .asyncinput(a_main),
    .stable(stable_main), .rise(rise_main), .fall(fall_main),
    .any_change(any_main)
  );

  sync_debouncer #(.WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .asyncinput(a_aux),
    .stable(stable_aux), .rise(rise_aux), .fall(fall_aux),
    .any_change(any_aux)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entry format: {cycle[31:16], stable[15:12], rise[11:8], fall[7:4], 4'h0}
  task automatic expect_main(input logic [3:0] nv);
    logic [3:0] r, f;
    r = (nv & ~s_model) & {4{EDGE}};
    f = (s_model & ~nv) & {4{EDGE}};
    exp_q.push_back({16'(cyc + LAT_MAIN), nv, r, f, 4'h0});
    s_model = nv;
  endtask

  task automatic expect_aux(input logic [3:0] nv);
    logic [3:0] r, f;
    r = (nv & ~s2_model) & {4{EDGE}};
    f = (s2_model & ~nv) & {4{EDGE}};
    exp2_q.push_back({16'(cyc + LAT_AUX), nv, r, f, 4'h0});
    s2_model = nv;
  endtask

  // Advance n rising edges, then move 2 ns past the last one so inputs
  // change in the middle of the cycle.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- monitor: main instance ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("main_reset_state", {stable_main, rise_main, fall_main, 3'b000, any_main}, '0);
      last_main = '0;
    end else if (stable_main !== last_main) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL main_unexpected_change: got %0h expected %0h (t=%0t)",
                 stable_main, last_main, $time);
      end else begin
        e_main = exp_q.pop_front();
        check("main_change_cycle", EW'(cyc), EW'(e_main[31:16]));
        check("main_stable", EW'(stable_main), EW'(e_main[15:12]));
        check("main_rise", EW'(rise_main), EW'(e_main[11:8]));
        check("main_fall", EW'(fall_main), EW'(e_main[7:4]));
        check("main_any", EW'(any_main), EW'(|e_main[11:4]));
      end
      last_main = stable_main;
    end else begin
      check("main_idle_pulses", {rise_main, fall_main, 3'b000, any_main}, '0);
    end
  end

  // ---------------- monitor: aux instance ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("aux_reset_state", {stable_aux, rise_aux, fall_aux, 3'b000, any_aux}, '0);
      last_aux = '0;
    end else if (stable_aux !== last_aux) begin
      if (exp2_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL aux_unexpected_change: got %0h expected %0h (t=%0t)",
                 stable_aux, last_aux, $time);
      end else begin
        e_aux = exp2_q.pop_front();
        check("aux_change_cycle", EW'(cyc), EW'(e_aux[31:16]));
        check("aux_stable", EW'(stable_aux), EW'(e_aux[15:12]));
        check("aux_rise", EW'(rise_aux), EW'(e_aux[11:8]));
        check("aux_fall", EW'(fall_aux), EW'(e_aux[7:4]));
        check("aux_any", EW'(any_aux), EW'(|e_aux[11:4]));
      end
      last_aux = stable_aux;
    end else begin
      check("aux_idle_pulses", {rise_aux, fall_aux, 3'b000, any_aux}, '0);
    end
  end

  // ---------------- driver ----------------
  initial begin
    reset    = 1'b0;
    a_main   = 4'hF;
    a_aux    = 4'b1000;
    s_model  = '0;
    s2_model = '0;

    // 1: reset is held for 22 ns with all inputs high. After release,
    //    stable should read 4'hF on the 6th edge.
    #22;
    reset = 1'b1;
    expect_main(4'hF);
    expect_aux(4'b1000);
    step(10);

    // Return to 0 so the next test starts from a known state.
    a_main = 4'h0;
    expect_main(4'h0);
    step(10);

    // 2: step to 0101 in the middle of the cycle.
    a_main = 4'b0101;
    expect_main(4'b0101);
    step(10);
    a_main = 4'h0;
    expect_main(4'h0);
    step(10);

    // 3: a 3-cycle glitch on bit0 must be filtered out (no entry queued).
    a_main = 4'b0001;
    step(3);
    a_main = 4'h0;
    step(10);

    // 4: bit2 bounces 1,0,1 and then holds 1. Acceptance is counted from
    //    the final 0->1 transition.
    a_main = 4'b0100;
    step(1);
    a_main = 4'b0000;
    step(1);
    a_main = 4'b0100;
    expect_main(4'b0100);
    step(10);

    // 5: reset is asserted while a count is in progress. The output must
    //    clear before the next edge, and only the held input comes back.
    a_main = 4'b1000;
    step(4);
    #1;
    reset = 1'b0;
    #1;
    check("async_clear_stable", EW'(stable_main), '0);
    check("async_clear_pulses", {rise_main, fall_main, 3'b000, any_main}, '0);
    check("async_clear_aux", EW'(stable_aux), '0);
    s_model  = '0;
    s2_model = '0;
    step(3);
    reset = 1'b1;
    expect_main(4'b1000);
    expect_aux(4'b1000);
    step(10);

    // 6: on the STAGES=3 / DEBOUNCE_CYCLES=1 instance, a 1->0 change on
    //    bit3 should reach stable after 4 edges.
    a_aux = 4'b0000;
    expect_aux(4'b0000);
    step(10);

    check("pending_main", EW'(exp_q.size()), '0);
    check("pending_aux", EW'(exp2_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
